uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NREQ byte-stream requesters. Arbitrates round-robin at packet granularity: a grant is held until the requester's last byte has been fully serialised. It can prefix each packet with an ID header byte. It sits between the per-channel message sources and the UART transmitter, drives the transmitter's start/data inputs and consumes its done tick.

Parameters:
NREQ, 4, number of requesters (2..16)
HDR_EN, 1, 1 = send header byte {HDR_TAG, id[3:0]} before each packet
HDR_TAG, 4'hA, upper nibble of header byte
TIMEOUT, 1024, clk cycles of a granted requester stalling (req_valid low) before the packet is aborted
TW, 11, timeout counter width (≥ clog2(TIMEOUT+1))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester byte available
req_data  in  8*NREQ  byte for requester i at [8i+7:8i]
req_last  in  NREQ  byte is last of packet
req_ready  out  NREQ  byte accepted this cycle (combinational, one-hot or zero)
grant  out  NREQ  one-hot current owner, registered; zero when idle
tx_start  out  1  one-cycle start pulse to transmitter, registered
tx_din  out  8  byte to transmitter, registered, stable while tx_start high and until next load
tx_done_tick  in  1  transmitter finished stop bit
busy  out  1  high in any state other than IDLE
abort_tick  out  1  one-cycle pulse when a packet is aborted by timeout

Behaviour:
- Reset (async): state IDLE; grant=0, tx_start=0, tx_din=0, busy=0, abort_tick=0, rr pointer=NREQ-1 (requester 0 has first priority), timeout counter=0, last_flag=0. Reset mid-packet abandons it silently; the transmitter is reset by the same signal.
- States: IDLE, HDR, SEND, WAIT.
- IDLE: if any req_valid, winner = first asserted index searching (ptr+1, ptr+2, …) modulo NREQ. Register grant=onehot(winner). Next state is HDR if HDR_EN, else SEND. No byte is accepted in IDLE.
- HDR: load tx_din={HDR_TAG, winner[3:0]}, pulse tx_start next cycle, last_flag=0, go to WAIT.
- SEND: req_ready[g] = req_valid[g] (combinational, only for granted g). On acceptance: tx_din<=req_data[g], tx_start<=1 for exactly one cycle, last_flag<=req_last[g], timeout counter cleared, go to WAIT. If req_valid[g] is low, increment the counter. When the counter reaches TIMEOUT-1: abort_tick pulse, grant=0, ptr<=g, go to IDLE.
- WAIT: ignore all requests. On tx_done_tick: if last_flag, set ptr<=g, grant=0, go to IDLE; else go to SEND.
- tx_start is never asserted while a transmission is in progress. The minimum gap from tx_done_tick to the next tx_start is 2 cycles.
- A requester deasserting req_valid mid-packet keeps the grant; only the timeout releases it.
- Simultaneous requests are resolved only by the rr pointer. A requester that just finished has lowest priority next round.
- tx_done_tick outside WAIT is ignored.
- Packet of k data bytes with HDR_EN=1 produces k+1 tx_start pulses.

Test Plan:
- Single packet: req0 sends 0x55,0x3C(last), HDR_EN=1 -> tx_din sequence 0xA0,0x55,0x3C; 3 tx_start pulses; each pulse follows the previous tx_done_tick by ≥2 cycles; grant returns 0.
- Fairness: all 4 requesters hold 1-byte packets continuously -> header IDs served in order 0,1,2,3,0; no requester served twice consecutively while others wait.
- Stall/timeout: req2 granted, sends 1 non-last byte, then drops valid for TIMEOUT cycles -> abort_tick exactly once, grant=0, next winner is req3 (if valid).
- Backpressure: req_valid held high during WAIT -> req_ready stays 0 until SEND, exactly one req_ready per tx_done_tick.
- Reset mid-byte: assert reset in WAIT -> all outputs 0 immediately; after release, req0 wins first when all request.
- HDR_EN=0: req1 sends 0xFF(last) -> single tx_start with tx_din=0xFF, no header.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NREQ
// byte-stream requesters, with an optional ID header byte ahead of each packet.
module uart_tx_arbiter #(
  parameter int          NREQ    = 4,
  parameter int          HDR_EN  = 1,
  parameter logic [3:0]  HDR_TAG = 4'hA,
  parameter int          TIMEOUT = 1024,
  parameter int          TW      = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic              abort_tick
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]    state;
  logic [3:0]    ptr;
  logic [3:0]    gidx;
  logic [TW-1:0] cnt;
  logic          last_flag;

  logic [3:0]    hi_idx, lo_idx, winner;
  logic          hi_found, lo_found, found;
  logic          g_valid, g_last;
  logic [7:0]    g_data;

  // Search order is ptr+1 .. NREQ-1 first, then 0 .. ptr; the descending loop
  // leaves the lowest matching index in each half.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (4'(i) > ptr) begin
          hi_idx   = 4'(i);
          hi_found = 1'b1;
        end else begin
          lo_idx   = 4'(i);
          lo_found = 1'b1;
        end
      end
    end
    found  = hi_found | lo_found;
    winner = hi_found ? hi_idx : lo_idx;
  end

  // Granted requester's inputs, selected by the one-hot grant vector.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) g_data = g_data | req_data[8*i +: 8];
    end
    g_valid = |(grant & req_valid);
    g_last  = |(grant & req_last);
  end

  always_comb begin
    req_ready = '0;
    if (state == S_SEND) req_ready = grant & req_valid;
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= 4'(NREQ - 1);
      gidx       <= '0;
      grant      <= '0;
      cnt        <= '0;
      last_flag  <= 1'b0;
      tx_start   <= 1'b0;
      tx_din     <= '0;
      abort_tick <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      abort_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= NREQ'(1) << winner;
            gidx  <= winner;
            cnt   <= '0;
            state <= (HDR_EN != 0) ? S_HDR : S_SEND;
          end
        end
        S_HDR: begin
          tx_din    <= {HDR_TAG, gidx};
          tx_start  <= 1'b1;
          last_flag <= 1'b0;
          state     <= S_WAIT;
        end
        S_SEND: begin
          if (g_valid) begin
            tx_din    <= g_data;
            tx_start  <= 1'b1;
            last_flag <= g_last;
            cnt       <= '0;
            state     <= S_WAIT;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            // Stalled owner loses the grant and drops to lowest priority.
            abort_tick <= 1'b1;
            grant      <= '0;
            ptr        <= gidx;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (tx_done_tick) begin
            if (last_flag) begin
              ptr   <= gidx;
              grant <= '0;
              state <= S_IDLE;
            end else begin
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: scoreboard of expected transmitter bytes, a behavioural
// transmitter model and per-requester packet queues drive two arbiter instances.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   a_valid, a_last, a_ready, a_grant;
  logic [8*NREQ-1:0] a_data;
  logic              a_start, a_done, a_busy, a_abort;
  logic [7:0]        a_din;

  logic [NREQ-1:0]   b_valid, b_last, b_ready, b_grant;
  logic [8*NREQ-1:0] b_data;
  logic              b_start, b_done, b_busy, b_abort;
  logic [7:0]        b_din;

  uart_tx_arbiter #(.NREQ(NREQ), .HDR_EN(1), .HDR_TAG(4'hA), .TIMEOUT(TO), .TW(5)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
    .req_ready(a_ready), .grant(a_grant), .tx_start(a_start), .tx_din(a_din),
    .tx_done_tick(a_done), .busy(a_busy), .abort_tick(a_abort));

  uart_tx_arbiter #(.NREQ(NREQ), .HDR_EN(0), .HDR_TAG(4'hA), .TIMEOUT(TO), .TW(5)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .grant(b_grant), .tx_start(b_start), .tx_din(b_din),
    .tx_done_tick(b_done), .busy(b_busy), .abort_tick(b_abort));

  int total = 0;
  int bad   = 0;

  logic [7:0]      exp_q [$];
  logic [8:0]      pq    [NREQ][$];
  logic [NREQ-1:0] stall = '0;
  logic [NREQ-1:0] ready_snap;

  bit tx_busy = 0;
  int tx_cnt = 0, cyc = 0, done_cyc = -100, start_count = 0;
  int abort_count = 0, abort_gap = 0, ready_since_done = 0;
  logic [NREQ-1:0] abort_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    a_valid = '0;
    a_last  = '0;
    a_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0 && !stall[i]) begin
        h = pq[i][0];
        a_valid[i]       = 1'b1;
        a_last[i]        = h[8];
        a_data[8*i +: 8] = h[7:0];
      end
    end
  endtask

  // One clock: sample req_ready mid-cycle, then after the edge retire accepted
  // bytes, refresh requester inputs and advance the transmitter model.
  task automatic step();
    @(negedge clk);
    ready_snap = a_ready;
    if (a_ready != '0) begin
      ready_since_done++;
      check("ready_onehot", 32'($onehot(a_ready)), 1);
      check("ready_while_tx", 32'(tx_busy), 0);
      check("one_ready_per_done", 32'(ready_since_done <= 1), 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (ready_snap[i]) void'(pq[i].pop_front());
    drive();
    a_done = 1'b0;
    if (a_abort) begin
      abort_count++;
      abort_gap   = cyc - done_cyc;
      abort_grant = a_grant;
    end
    if (a_start) begin
      check("start_while_busy", 32'(tx_busy), 0);
      check("done_to_start_gap", 32'((cyc - done_cyc) >= 2), 1);
      check("sb_underflow", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("tx_din", 32'(a_din), 32'(exp_q.pop_front()));
      start_count++;
      tx_busy = 1;
      tx_cnt  = 4;
    end else if (tx_busy) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy          = 0;
        a_done           = 1'b1;
        done_cyc         = cyc;
        ready_since_done = 0;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      ok = !a_busy && !tx_busy && exp_q.size() == 0;
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic wait_grant(input string tag, input logic [NREQ-1:0] g, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      ok = (a_grant == g);
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      ok = (start_count >= target);
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(a_grant), 0);
    check({tag, "_start"}, 32'(a_start), 0);
    check({tag, "_din"},   32'(a_din),   0);
    check({tag, "_busy"},  32'(a_busy),  0);
    check({tag, "_abort"}, 32'(a_abort), 0);
    check({tag, "_ready"}, 32'(a_ready), 0);
  endtask

  initial begin
    int bstarts;
    logic [7:0] bdin;
    logic [NREQ-1:0] bgrant_seen, rs;

    reset = 1'b1;
    a_valid = '0; a_last = '0; a_data = '0; a_done = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Single packet from requester 0: header then two data bytes.
    exp_q = '{8'hA0, 8'h55, 8'h3C};
    pq[0].push_back({1'b0, 8'h55});
    pq[0].push_back({1'b1, 8'h3C});
    drive();
    start_count = 0;
    wait_idle("single_done", 200);
    check("single_starts", 32'(start_count), 3);
    check("single_grant", 32'(a_grant), 0);

    // Fairness: requester 0 just finished, so service runs 1,2,3,0 then 1 again.
    for (int i = 0; i < NREQ; i++) pq[i].push_back({1'b1, 8'h10 + 8'(i)});
    pq[1].push_back({1'b1, 8'h51});
    exp_q = '{8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h10, 8'hA1, 8'h51};
    drive();
    wait_idle("fair_done", 400);

    // Stall/timeout: requester 2 sends one non-last byte then goes quiet.
    pq[2].push_back({1'b0, 8'h77});
    exp_q = '{8'hA2, 8'h77};
    drive();
    wait_grant("to_grant2", 4'b0100, 20);
    pq[3].push_back({1'b1, 8'h33});
    pq[0].push_back({1'b1, 8'h30});
    pq[1].push_back({1'b1, 8'h31});
    exp_q.push_back(8'hA3); exp_q.push_back(8'h33);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h30);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h31);
    abort_count = 0;
    wait_idle("to_done", 400);
    check("abort_count", 32'(abort_count), 1);
    check("abort_latency", 32'(abort_gap), 32'(TO + 1));
    check("abort_grant", 32'(abort_grant), 0);

    // Reset while a data byte is on the wire.
    pq[1].push_back({1'b0, 8'h99});
    pq[1].push_back({1'b1, 8'h9A});
    exp_q = '{8'hA1, 8'h99, 8'h9A};
    drive();
    wait_starts("rst_reach_byte", start_count + 2, 100);
    step();
    #2 reset = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    tx_busy = 0;
    a_done = 1'b0;
    ready_since_done = 0;
    drive();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) pq[i].push_back({1'b1, 8'h20 + 8'(i)});
    exp_q = '{8'hA0, 8'h20, 8'hA1, 8'h21, 8'hA2, 8'h22, 8'hA3, 8'h23};
    drive();
    wait_idle("post_rst_done", 400);

    // Headerless instance: a single 0xFF byte produces a single start.
    bstarts = 0;
    bdin = '0;
    bgrant_seen = '0;
    b_valid[1] = 1'b1;
    b_last[1]  = 1'b1;
    b_data[15:8] = 8'hFF;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      rs = b_ready;
      @(posedge clk);
      #1;
      b_done = (n == 6);
      if (rs[1]) b_valid[1] = 1'b0;
      bgrant_seen = bgrant_seen | b_grant;
      if (b_start) begin
        bstarts++;
        bdin = b_din;
      end
    end
    b_done = 1'b0;
    check("nohdr_starts", 32'(bstarts), 1);
    check("nohdr_din", 32'(bdin), 32'h0FF);
    check("nohdr_grant_seen", 32'(bgrant_seen), 32'b0010);
    check("nohdr_grant_end", 32'(b_grant), 0);
    check("nohdr_busy_end", 32'(b_busy), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
